demux_8x1_deserializer: RTL

Sequential 1-to-8 demultiplexing deserializer: a 3-bit slot counter steers each valid serial input bit to one bit position of an 8-bit assembly register. Completed words are handed to a consumer through a valid/ready output register. It is the receive-side counterpart of the 8x1 mux select path: the mux picks bit I[S] onto one line, and this block writes one line back into bit I[S] with S advanced by hardware. It sits between a 1-bit serial link and 8-bit parallel logic.

---
 rtl/demux_8x1_deserializer_pkg.sv | 13 +
 rtl/demux_8x1_deserializer_demux_1x8.sv | 17 +
 rtl/demux_8x1_deserializer.sv | 83 ++++++++
 3 files changed

// File: rtl/demux_8x1_deserializer_pkg.sv
// Shared widths and slot-ordering helper for the 1-to-8 serial deserializer.
package demux_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned SLOT_W = 3;

  // Maps the received-bit count onto the assembly register bit position.
  function automatic logic [SLOT_W-1:0] slot_of(input logic [SLOT_W-1:0] cnt,
                                               input logic              lsb_first);
    return lsb_first ? cnt : SLOT_W'(WORD_W - 1) - cnt;
  endfunction

endpackage

// File: rtl/demux_8x1_deserializer_demux_1x8.sv
// Combinational 1-to-8 decoder: one-hot write enable for the selected slot.
module demux_1x8
  import demux_pkg::*;
(
  input  logic              en,
  input  logic [SLOT_W-1:0] sel,
  output logic [WORD_W-1:0] we
);

  always_comb begin
    we = '0;
    if (en) begin
      we[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_8x1_deserializer.sv
// Serial-to-parallel deserializer: steers valid bits into an 8-bit word and
// presents completed words through a valid/ready output register.
module demux_8x1_deserializer
  import demux_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic              clear,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [SLOT_W-1:0] slot,
  output logic              overrun
);

  logic [SLOT_W-1:0] r_cnt;
  logic [WORD_W-1:0] r_asm;
  logic [WORD_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_overrun;

  logic              w_bit_en;
  logic [SLOT_W-1:0] w_slot;
  logic [WORD_W-1:0] w_we;
  logic [WORD_W-1:0] w_asm_next;
  logic              w_complete;
  logic              w_xfer;
  logic              w_out_free;

  assign w_slot   = slot_of(r_cnt, LSB_FIRST);
  assign w_bit_en = din_valid & ~clear;

  demux_1x8 u_demux (
    .en  (w_bit_en),
    .sel (w_slot),
    .we  (w_we)
  );

  // Completed word includes the bit arriving this cycle.
  assign w_asm_next = (r_asm & ~w_we) | ({WORD_W{din}} & w_we);
  assign w_complete = w_bit_en && (r_cnt == SLOT_W'(WORD_W - 1));
  assign w_xfer     = r_dout_valid & dout_ready;
  assign w_out_free = ~r_dout_valid | dout_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_asm        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (clear) begin
        r_cnt     <= '0;
        r_asm     <= '0;
        r_overrun <= 1'b0;
      end else if (din_valid) begin
        r_asm <= w_asm_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_complete && !w_out_free) begin
          r_overrun <= 1'b1;
        end
      end

      if (w_complete && w_out_free) begin
        r_dout       <= w_asm_next;
        r_dout_valid <= 1'b1;
      end else if (w_xfer) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign slot       = w_slot;
  assign overrun    = r_overrun;

endmodule
